d_e_pipe_reg: RTL and testbench
===============================

Name: d_e_pipe_reg

Overview:
ID/EX pipeline register sitting directly downstream of the decode control unit. It latches the decode control bundle, operand data, immediate and register addresses into the execute stage. It detects load-use hazards against the instruction currently in EX and inserts a one-cycle bubble with a decode stall. It also honours a global hold and a branch flush.

Parameters:
DATA_W, 32, width of operand, immediate and PC datapaths
REG_AW, 5, register-file address width

Ports:
i_clk  in  1  clock, all state updates on rising edge
i_rst  in  1  synchronous active-high reset
i_hold  in  1  downstream busy; freeze all E-stage state
i_flush  in  1  branch/jump redirect; kill the instruction being latched
i_d_valid  in  1  decode-stage instruction valid
i_con_regdst, i_con_memread, i_con_memtoreg, i_con_memwrite, i_con_alusrc, i_con_regwrite, i_con_ifsign  in  1 each  decode control bits
i_con_loadsig  in  2  load-width select from decode
i_con_aluop  in  6  ALU opcode from decode
i_d_rs_data, i_d_rt_data, i_d_imm, i_d_pc4  in  DATA_W each  operands, sign-extended immediate, PC+4
i_d_rs, i_d_rt, i_d_rd  in  REG_AW each  register addresses
o_e_valid  out  1  E-stage slot holds a real instruction
o_e_regdst ... o_e_ifsign, o_e_loadsig[1:0], o_e_aluop[5:0]  out  registered copies of the control inputs
o_e_rs_data, o_e_rt_data, o_e_imm, o_e_pc4  out  DATA_W  registered data
o_e_rs, o_e_rt, o_e_rd  out  REG_AW  registered addresses
o_e_wreg  out  REG_AW  destination: rd if regdst=1, else rt
o_d_stall  out  1  combinational; decode/fetch must hold their current instruction

Behaviour:
- Reset (i_rst=1 at edge): every output register goes to 0, including o_e_valid, all controls and all data. Reset overrides all other inputs.
- rs_used = i_d_valid and (i_con_aluop != 6'b011111). lui does not read rs.
- rt_used = i_d_valid and (i_con_regdst or i_con_memwrite). R-type or store.
- hazard = o_e_valid and o_e_memread and o_e_rt != 0 and ((rs_used and o_e_rt == i_d_rs) or (rt_used and o_e_rt == i_d_rt)).
- o_d_stall = (hazard and not i_flush) or i_hold. This is combinational, same cycle.
- Priority at each edge, highest first: reset > i_hold > i_flush > hazard > load.
  - hold: all E registers keep their value.
  - flush: bubble. o_e_valid=0; regwrite, memwrite, memread, memtoreg = 0; aluop = 0. Data registers are don't-care (implementation zeroes them).
  - hazard: bubble as for flush. Decode holds, so the same instruction is re-presented next cycle.
  - load: all fields captured; o_e_valid = i_d_valid.
- Latency: 1 cycle from decode inputs to o_e_*.
- i_d_valid=0 loads a bubble: o_e_valid=0 and write/mem controls are forced to 0 regardless of the decode inputs.
- Load-use stall lasts exactly 1 cycle. After the bubble, the E slot no longer holds the load, so hazard clears.
- Back-to-back loads with a dependence also stall 1 cycle each.
- $0 (address 0) never triggers a hazard.
- i_flush with hazard in the same cycle: the flush wins and o_d_stall stays 0. The redirected fetch replaces the dependent instruction.
- i_hold with hazard: hold wins. The hazard is re-evaluated after the hold releases.
- o_e_wreg is registered and computed from the inputs at load time. It is 0 on bubbles.

Optional Feature:
DE_BUBBLE_CNT_EN
- Defined: adds outputs o_bubble_cnt[15:0] and o_hazard_cnt[15:0].
  - o_bubble_cnt increments on every non-reset, non-hold edge where a bubble is loaded, whatever the cause.
  - o_hazard_cnt increments only on hazard bubbles.
  - Both saturate at 16'hFFFF, clear on i_rst, and freeze during i_hold.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Reset: i_rst=1 for 2 cycles with random inputs -> all outputs 0, o_d_stall=0 (with i_hold=0).
- lw writing $8 in E (o_e_rt=8, memread=1); D presents add $9,$8,$10 (regdst=1, i_d_rs=8) -> o_d_stall=1 for exactly 1 cycle, then E valid=0 and regwrite=0, then the add loads with o_e_wreg=9.
- lw rt=8 in E; D presents addi rt=8, rs=3 (rt is dest only) -> no stall; addi loads next edge.
- lw rt=0 in E; D rs=0 -> no stall.
- Hazard and i_flush asserted together -> o_d_stall=0 and the next E slot is a bubble (valid=0, memwrite=0).
- i_hold=1 for 3 cycles mid-stream -> o_e_* unchanged throughout, o_d_stall=1. On release the pending D instruction loads.
- With DE_BUBBLE_CNT_EN: 2 hazards plus 1 flush -> o_bubble_cnt=3, o_hazard_cnt=2. Preloading 16'hFFFE then 3 bubbles -> o_bubble_cnt=16'hFFFF.

Source files
------------

// File: rtl/d_e_pipe_reg.sv
// ID/EX pipeline register with load-use hazard bubble insertion, hold and flush.
// Optional bubble/hazard counters are enabled by defining DE_BUBBLE_CNT_EN.
module d_e_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_hold,
  input  logic              i_flush,
  input  logic              i_d_valid,
  input  logic              i_con_regdst,
  input  logic              i_con_memread,
  input  logic              i_con_memtoreg,
  input  logic              i_con_memwrite,
  input  logic              i_con_alusrc,
  input  logic              i_con_regwrite,
  input  logic              i_con_ifsign,
  input  logic [1:0]        i_con_loadsig,
  input  logic [5:0]        i_con_aluop,
  input  logic [DATA_W-1:0] i_d_rs_data,
  input  logic [DATA_W-1:0] i_d_rt_data,
  input  logic [DATA_W-1:0] i_d_imm,
  input  logic [DATA_W-1:0] i_d_pc4,
  input  logic [REG_AW-1:0] i_d_rs,
  input  logic [REG_AW-1:0] i_d_rt,
  input  logic [REG_AW-1:0] i_d_rd,
  output logic              o_e_valid,
  output logic              o_e_regdst,
  output logic              o_e_memread,
  output logic              o_e_memtoreg,
  output logic              o_e_memwrite,
  output logic              o_e_alusrc,
  output logic              o_e_regwrite,
  output logic              o_e_ifsign,
  output logic [1:0]        o_e_loadsig,
  output logic [5:0]        o_e_aluop,
  output logic [DATA_W-1:0] o_e_rs_data,
  output logic [DATA_W-1:0] o_e_rt_data,
  output logic [DATA_W-1:0] o_e_imm,
  output logic [DATA_W-1:0] o_e_pc4,
  output logic [REG_AW-1:0] o_e_rs,
  output logic [REG_AW-1:0] o_e_rt,
  output logic [REG_AW-1:0] o_e_rd,
  output logic [REG_AW-1:0] o_e_wreg,
`ifdef DE_BUBBLE_CNT_EN
  output logic [15:0]       o_bubble_cnt,
  output logic [15:0]       o_hazard_cnt,
`endif
  output logic              o_d_stall
);

  localparam logic [5:0] ALUOP_LUI = 6'b011111;

  typedef struct packed {
    logic              valid;
    logic              regdst;
    logic              memread;
    logic              memtoreg;
    logic              memwrite;
    logic              alusrc;
    logic              regwrite;
    logic              ifsign;
    logic [1:0]        loadsig;
    logic [5:0]        aluop;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc4;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] wreg;
  } e_stage_t;

  typedef enum logic [1:0] {
    UPD_HOLD   = 2'd0,
    UPD_BUBBLE = 2'd1,
    UPD_LOAD   = 2'd2
  } upd_e;

  localparam e_stage_t E_BUBBLE = {$bits(e_stage_t){1'b0}};

  e_stage_t e_r;
  e_stage_t load_s;
  e_stage_t next_s;
  upd_e     upd_s;
  logic     rs_used_s;
  logic     rt_used_s;
  logic     hazard_s;

  // Load-use detection against the load currently sitting in E; $0 is never a hazard.
  always_comb begin
    rs_used_s = i_d_valid & (i_con_aluop != ALUOP_LUI);
    rt_used_s = i_d_valid & (i_con_regdst | i_con_memwrite);
    hazard_s  = e_r.valid & e_r.memread & (e_r.rt != {REG_AW{1'b0}}) &
                ((rs_used_s & (e_r.rt == i_d_rs)) | (rt_used_s & (e_r.rt == i_d_rt)));
  end

  assign o_d_stall = (hazard_s & ~i_flush) | i_hold;

  // Build the capture bundle; an invalid decode slot loads with write/mem controls killed.
  always_comb begin
    load_s          = E_BUBBLE;
    load_s.valid    = i_d_valid;
    load_s.regdst   = i_con_regdst;
    load_s.memread  = i_con_memread & i_d_valid;
    load_s.memtoreg = i_con_memtoreg & i_d_valid;
    load_s.memwrite = i_con_memwrite & i_d_valid;
    load_s.alusrc   = i_con_alusrc;
    load_s.regwrite = i_con_regwrite & i_d_valid;
    load_s.ifsign   = i_con_ifsign;
    load_s.loadsig  = i_con_loadsig;
    load_s.aluop    = i_con_aluop;
    load_s.rs_data  = i_d_rs_data;
    load_s.rt_data  = i_d_rt_data;
    load_s.imm      = i_d_imm;
    load_s.pc4      = i_d_pc4;
    load_s.rs       = i_d_rs;
    load_s.rt       = i_d_rt;
    load_s.rd       = i_d_rd;
    if (!i_d_valid) begin
      load_s.wreg = {REG_AW{1'b0}};
    end else if (i_con_regdst) begin
      load_s.wreg = i_d_rd;
    end else begin
      load_s.wreg = i_d_rt;
    end
  end

  // Update priority: hold, then flush/hazard bubble, then normal load.
  always_comb begin
    upd_s  = UPD_LOAD;
    next_s = load_s;
    if (i_hold) begin
      upd_s = UPD_HOLD;
    end else if (i_flush || hazard_s) begin
      upd_s = UPD_BUBBLE;
    end else begin
      upd_s = UPD_LOAD;
    end
    case (upd_s)
      UPD_HOLD:   next_s = e_r;
      UPD_BUBBLE: next_s = E_BUBBLE;
      UPD_LOAD:   next_s = load_s;
      default:    next_s = E_BUBBLE;
    endcase
  end

  // E-stage register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      e_r <= E_BUBBLE;
    end else begin
      e_r <= next_s;
    end
  end

  assign o_e_valid    = e_r.valid;
  assign o_e_regdst   = e_r.regdst;
  assign o_e_memread  = e_r.memread;
  assign o_e_memtoreg = e_r.memtoreg;
  assign o_e_memwrite = e_r.memwrite;
  assign o_e_alusrc   = e_r.alusrc;
  assign o_e_regwrite = e_r.regwrite;
  assign o_e_ifsign   = e_r.ifsign;
  assign o_e_loadsig  = e_r.loadsig;
  assign o_e_aluop    = e_r.aluop;
  assign o_e_rs_data  = e_r.rs_data;
  assign o_e_rt_data  = e_r.rt_data;
  assign o_e_imm      = e_r.imm;
  assign o_e_pc4      = e_r.pc4;
  assign o_e_rs       = e_r.rs;
  assign o_e_rt       = e_r.rt;
  assign o_e_rd       = e_r.rd;
  assign o_e_wreg     = e_r.wreg;

`ifdef DE_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt_r;
  logic [15:0] hazard_cnt_r;
  logic        bubble_load_s;
  logic        hazard_bubble_s;

  // Any bubble entering E counts, including an invalid decode slot; hazard bubbles only when not flushed.
  always_comb begin
    bubble_load_s   = (upd_s == UPD_BUBBLE) | ((upd_s == UPD_LOAD) & ~i_d_valid);
    hazard_bubble_s = (upd_s == UPD_BUBBLE) & ~i_flush;
  end

  // Saturating event counters; hold is covered because upd_s is UPD_HOLD then.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bubble_cnt_r <= 16'h0000;
      hazard_cnt_r <= 16'h0000;
    end else begin
      if (bubble_load_s && (bubble_cnt_r != 16'hFFFF)) begin
        bubble_cnt_r <= bubble_cnt_r + 16'h0001;
      end
      if (hazard_bubble_s && (hazard_cnt_r != 16'hFFFF)) begin
        hazard_cnt_r <= hazard_cnt_r + 16'h0001;
      end
    end
  end

  assign o_bubble_cnt = bubble_cnt_r;
  assign o_hazard_cnt = hazard_cnt_r;
`endif

endmodule

// File: tb/tb_d_e_pipe_reg.sv
// Directed bench for d_e_pipe_reg: reset, load-use stall, $0/lui exemptions, flush, hold.
module tb_d_e_pipe_reg;

  logic        i_clk = 1'b0;
  logic        i_rst, i_hold, i_flush, i_d_valid;
  logic        i_con_regdst, i_con_memread, i_con_memtoreg, i_con_memwrite;
  logic        i_con_alusrc, i_con_regwrite, i_con_ifsign;
  logic [1:0]  i_con_loadsig;
  logic [5:0]  i_con_aluop;
  logic [31:0] i_d_rs_data, i_d_rt_data, i_d_imm, i_d_pc4;
  logic [4:0]  i_d_rs, i_d_rt, i_d_rd;
  logic        o_e_valid, o_e_regdst, o_e_memread, o_e_memtoreg, o_e_memwrite;
  logic        o_e_alusrc, o_e_regwrite, o_e_ifsign, o_d_stall;
  logic [1:0]  o_e_loadsig;
  logic [5:0]  o_e_aluop;
  logic [31:0] o_e_rs_data, o_e_rt_data, o_e_imm, o_e_pc4;
  logic [4:0]  o_e_rs, o_e_rt, o_e_rd, o_e_wreg;
`ifdef DE_BUBBLE_CNT_EN
  logic [15:0] o_bubble_cnt, o_hazard_cnt;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  localparam logic [5:0] OP_ADD  = 6'b100000;
  localparam logic [5:0] OP_MEM  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LUI  = 6'b011111;

  d_e_pipe_reg dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_hold(i_hold), .i_flush(i_flush), .i_d_valid(i_d_valid),
    .i_con_regdst(i_con_regdst), .i_con_memread(i_con_memread), .i_con_memtoreg(i_con_memtoreg),
    .i_con_memwrite(i_con_memwrite), .i_con_alusrc(i_con_alusrc), .i_con_regwrite(i_con_regwrite),
    .i_con_ifsign(i_con_ifsign), .i_con_loadsig(i_con_loadsig), .i_con_aluop(i_con_aluop),
    .i_d_rs_data(i_d_rs_data), .i_d_rt_data(i_d_rt_data), .i_d_imm(i_d_imm), .i_d_pc4(i_d_pc4),
    .i_d_rs(i_d_rs), .i_d_rt(i_d_rt), .i_d_rd(i_d_rd),
    .o_e_valid(o_e_valid), .o_e_regdst(o_e_regdst), .o_e_memread(o_e_memread),
    .o_e_memtoreg(o_e_memtoreg), .o_e_memwrite(o_e_memwrite), .o_e_alusrc(o_e_alusrc),
    .o_e_regwrite(o_e_regwrite), .o_e_ifsign(o_e_ifsign), .o_e_loadsig(o_e_loadsig),
    .o_e_aluop(o_e_aluop), .o_e_rs_data(o_e_rs_data), .o_e_rt_data(o_e_rt_data),
    .o_e_imm(o_e_imm), .o_e_pc4(o_e_pc4), .o_e_rs(o_e_rs), .o_e_rt(o_e_rt), .o_e_rd(o_e_rd),
    .o_e_wreg(o_e_wreg),
`ifdef DE_BUBBLE_CNT_EN
    .o_bubble_cnt(o_bubble_cnt), .o_hazard_cnt(o_hazard_cnt),
`endif
    .o_d_stall(o_d_stall)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Present one decode instruction; data fields are derived from the register numbers.
  task automatic drive(input logic v, input logic [5:0] op, input logic rdst, input logic mrd,
                       input logic mwr, input logic rwr, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd);
    i_d_valid      = v;
    i_con_aluop    = op;
    i_con_regdst   = rdst;
    i_con_memread  = mrd;
    i_con_memtoreg = mrd;
    i_con_memwrite = mwr;
    i_con_regwrite = rwr;
    i_con_alusrc   = ~rdst;
    i_con_ifsign   = 1'b1;
    i_con_loadsig  = mrd ? 2'b11 : 2'b00;
    i_d_rs         = rs;
    i_d_rt         = rt;
    i_d_rd         = rd;
    i_d_rs_data    = 32'hA000_0000 + {27'd0, rs};
    i_d_rt_data    = 32'hB000_0000 + {27'd0, rt};
    i_d_imm        = 32'h0000_0010;
    i_d_pc4        = 32'h0040_0004;
    #1;
  endtask

  initial begin
    // Reset with random inputs
    i_rst = 1'b1; i_hold = 1'b0; i_flush = 1'b0;
    drive(1'($urandom), 6'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
    i_d_rs_data = $urandom;
    tick(); tick();
    check_eq("rst_valid", 64'(o_e_valid), 64'd0);
    check_eq("rst_regwrite", 64'(o_e_regwrite), 64'd0);
    check_eq("rst_memread", 64'(o_e_memread), 64'd0);
    check_eq("rst_aluop", 64'(o_e_aluop), 64'd0);
    check_eq("rst_rs_data", 64'(o_e_rs_data), 64'd0);
    check_eq("rst_wreg", 64'(o_e_wreg), 64'd0);
    check_eq("rst_stall", 64'(o_d_stall), 64'd0);
    i_rst = 1'b0;

    // lw $8 -> E, then dependent add $9,$8,$10
    drive(1'b1, OP_MEM, 1'b0, 1'b1, 1'b0, 1'b1, 5'd4, 5'd8, 5'd0);
    check_eq("lw_no_stall", 64'(o_d_stall), 64'd0);
    tick();
    check_eq("lw_valid", 64'(o_e_valid), 64'd1);
    check_eq("lw_memread", 64'(o_e_memread), 64'd1);
    check_eq("lw_wreg", 64'(o_e_wreg), 64'd8);
    check_eq("lw_rs_data", 64'(o_e_rs_data), 64'hA000_0004);
    drive(1'b1, OP_ADD, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 5'd10, 5'd9);
    check_eq("luse_stall", 64'(o_d_stall), 64'd1);
    tick();
    check_eq("luse_bub_valid", 64'(o_e_valid), 64'd0);
    check_eq("luse_bub_regwrite", 64'(o_e_regwrite), 64'd0);
    check_eq("luse_bub_wreg", 64'(o_e_wreg), 64'd0);
    check_eq("luse_stall_clear", 64'(o_d_stall), 64'd0);
    tick();
    check_eq("add_valid", 64'(o_e_valid), 64'd1);
    check_eq("add_wreg", 64'(o_e_wreg), 64'd9);
    check_eq("add_aluop", 64'(o_e_aluop), 64'(OP_ADD));
    check_eq("add_rt_data", 64'(o_e_rt_data), 64'hB000_000A);

    // addi writes rt=8 only: no hazard
    drive(1'b1, OP_MEM, 1'b0, 1'b1, 1'b0, 1'b1, 5'd4, 5'd8, 5'd0);
    tick();
    drive(1'b1, OP_ADDI, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 5'd8, 5'd0);
    check_eq("addi_no_stall", 64'(o_d_stall), 64'd0);
    tick();
    check_eq("addi_valid", 64'(o_e_valid), 64'd1);
    check_eq("addi_wreg", 64'(o_e_wreg), 64'd8);

    // lui does not read rs
    drive(1'b1, OP_MEM, 1'b0, 1'b1, 1'b0, 1'b1, 5'd4, 5'd8, 5'd0);
    tick();
    drive(1'b1, OP_LUI, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 5'd9, 5'd0);
    check_eq("lui_no_stall", 64'(o_d_stall), 64'd0);
    tick();
    check_eq("lui_wreg", 64'(o_e_wreg), 64'd9);

    // lw to $0 never hazards
    drive(1'b1, OP_MEM, 1'b0, 1'b1, 1'b0, 1'b1, 5'd4, 5'd0, 5'd0);
    tick();
    drive(1'b1, OP_ADD, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd5, 5'd6);
    check_eq("zero_no_stall", 64'(o_d_stall), 64'd0);
    tick();
    check_eq("zero_add_valid", 64'(o_e_valid), 64'd1);
    check_eq("zero_add_wreg", 64'(o_e_wreg), 64'd6);

    // Hazard together with flush
    drive(1'b1, OP_MEM, 1'b0, 1'b1, 1'b0, 1'b1, 5'd4, 5'd8, 5'd0);
    tick();
    drive(1'b1, OP_ADD, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 5'd10, 5'd9);
    i_flush = 1'b1; #1;
    check_eq("flush_haz_stall", 64'(o_d_stall), 64'd0);
    tick();
    i_flush = 1'b0;
    check_eq("flush_valid", 64'(o_e_valid), 64'd0);
    check_eq("flush_memwrite", 64'(o_e_memwrite), 64'd0);
    check_eq("flush_regwrite", 64'(o_e_regwrite), 64'd0);

    // Store reading rt of the load stalls
    drive(1'b1, OP_MEM, 1'b0, 1'b1, 1'b0, 1'b1, 5'd4, 5'd7, 5'd0);
    tick();
    drive(1'b1, OP_MEM, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2, 5'd7, 5'd0);
    check_eq("sw_stall", 64'(o_d_stall), 64'd1);
    tick();
    check_eq("sw_bub_valid", 64'(o_e_valid), 64'd0);
    tick();
    check_eq("sw_memwrite", 64'(o_e_memwrite), 64'd1);
    check_eq("sw_rt", 64'(o_e_rt), 64'd7);

    // Hold for 3 cycles with a new instruction pending
    drive(1'b1, OP_ADDI, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 5'd11, 5'd0);
    i_hold = 1'b1; #1;
    for (int k = 0; k < 3; k++) begin
      check_eq("hold_stall", 64'(o_d_stall), 64'd1);
      tick();
      check_eq("hold_memwrite", 64'(o_e_memwrite), 64'd1);
      check_eq("hold_aluop", 64'(o_e_aluop), 64'(OP_MEM));
      check_eq("hold_rs", 64'(o_e_rs), 64'd2);
    end
    i_hold = 1'b0;
    tick();
    check_eq("release_aluop", 64'(o_e_aluop), 64'(OP_ADDI));
    check_eq("release_wreg", 64'(o_e_wreg), 64'd11);
    check_eq("release_memwrite", 64'(o_e_memwrite), 64'd0);

    // Invalid decode slot loads a bubble
    drive(1'b0, OP_ADDI, 1'b1, 1'b1, 1'b1, 1'b1, 5'd1, 5'd2, 5'd3);
    tick();
    check_eq("inv_valid", 64'(o_e_valid), 64'd0);
    check_eq("inv_regwrite", 64'(o_e_regwrite), 64'd0);
    check_eq("inv_memwrite", 64'(o_e_memwrite), 64'd0);
    check_eq("inv_memread", 64'(o_e_memread), 64'd0);
    check_eq("inv_wreg", 64'(o_e_wreg), 64'd0);

    // Hold wins over hazard; hazard re-evaluated after release
    drive(1'b1, OP_MEM, 1'b0, 1'b1, 1'b0, 1'b1, 5'd4, 5'd8, 5'd0);
    tick();
    drive(1'b1, OP_ADD, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 5'd10, 5'd9);
    i_hold = 1'b1; #1;
    check_eq("holdhaz_stall", 64'(o_d_stall), 64'd1);
    tick();
    check_eq("holdhaz_memread", 64'(o_e_memread), 64'd1);
    check_eq("holdhaz_rt", 64'(o_e_rt), 64'd8);
    i_hold = 1'b0; #1;
    check_eq("holdhaz_stall2", 64'(o_d_stall), 64'd1);
    tick();
    check_eq("holdhaz_bub", 64'(o_e_valid), 64'd0);
    tick();
    check_eq("holdhaz_add_wreg", 64'(o_e_wreg), 64'd9);
    check_eq("holdhaz_add_valid", 64'(o_e_valid), 64'd1);
`ifdef DE_BUBBLE_CNT_EN
    // Bubbles: add hazard, flush, sw hazard, invalid slot, add hazard; 3 of them hazards
    check_eq("bubble_cnt", 64'(o_bubble_cnt), 64'd5);
    check_eq("hazard_cnt", 64'(o_hazard_cnt), 64'd3);
`endif

    // Reset overrides hold
    i_hold = 1'b1; i_rst = 1'b1;
    tick();
    i_hold = 1'b0; i_rst = 1'b0;
    check_eq("rst_over_hold_valid", 64'(o_e_valid), 64'd0);
    check_eq("rst_over_hold_wreg", 64'(o_e_wreg), 64'd0);
`ifdef DE_BUBBLE_CNT_EN
    check_eq("rst_bubble_cnt", 64'(o_bubble_cnt), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
